// File: rtl/hsi_pkg.sv
// Shared types and constants for the HSI cross-product front end.
//   packer_state_t : packer FSM encoding
//   IDX_*          : component position within one vector (H, S, I order)
package hsi_pkg;

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    PUSH      = 2'd2
  } packer_state_t;

  localparam logic [1:0] IDX_H = 2'd0;
  localparam logic [1:0] IDX_S = 2'd1;
  localparam logic [1:0] IDX_I = 2'd2;

endpackage

// File: rtl/hsi_vector_packer.sv
// Packs a serial stream of signed H,S,I components (vector A then vector B)
// into two 3*COMPONENT_WIDTH words and writes them to input FIFO 1 and 2 in
// the same cycle, so the FIFOs stay pair-aligned.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data     : component stream (valid/ready handshake)
//   flush                      : synchronous discard of partial/pending pair
//   in1_wr_en/in1_data_in/in1_full : FIFO 1 write port (vector A)
//   in2_wr_en/in2_data_in/in2_full : FIFO 2 write port (vector B)
//   busy                       : partial vector held or pair pending
//   pair_count                 : pairs written, wraps
module hsi_vector_packer
  import hsi_pkg::*;
#(
  parameter int unsigned COMPONENT_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [COMPONENT_WIDTH-1:0]   s_data,
  input  logic                         flush,
  output logic                         in1_wr_en,
  output logic [3*COMPONENT_WIDTH-1:0] in1_data_in,
  input  logic                         in1_full,
  output logic                         in2_wr_en,
  output logic [3*COMPONENT_WIDTH-1:0] in2_data_in,
  input  logic                         in2_full,
  output logic                         busy,
  output logic [COUNT_WIDTH-1:0]       pair_count
);

  localparam int unsigned W  = COMPONENT_WIDTH;
  localparam int unsigned VW = 3 * COMPONENT_WIDTH;

  packer_state_t    state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [VW-1:0]    vec_a_q, vec_b_q;
  logic [VW-1:0]    cur_vec, upd_vec;
  logic             xfer;
  logic             write;
  logic [COUNT_WIDTH-1:0] pair_count_q;

  always_comb begin
    s_ready = ((state_q == COLLECT_A) || (state_q == COLLECT_B)) && !flush;
    xfer    = s_valid && s_ready;
    write   = (state_q == PUSH) && !in1_full && !in2_full && !flush;

    state_d = state_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = COLLECT_A;
      idx_d   = IDX_H;
    end else begin
      case (state_q)
        COLLECT_A: begin
          if (xfer) begin
            if (idx_q == IDX_I) begin
              state_d = COLLECT_B;
              idx_d   = IDX_H;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        COLLECT_B: begin
          if (xfer) begin
            if (idx_q == IDX_I) begin
              state_d = PUSH;
              idx_d   = IDX_H;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        PUSH: begin
          if (write) state_d = COLLECT_A;
        end
        default: begin
          state_d = COLLECT_A;
          idx_d   = IDX_H;
        end
      endcase
    end
  end

  // Insert the incoming component into whichever vector is being collected;
  // H lands in the MSBs, I in the LSBs.
  always_comb begin
    cur_vec = (state_q == COLLECT_A) ? vec_a_q : vec_b_q;
    upd_vec = cur_vec;
    case (idx_q)
      IDX_H:   upd_vec[VW-1  -: W] = s_data;
      IDX_S:   upd_vec[2*W-1 -: W] = s_data;
      default: upd_vec[W-1   -: W] = s_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT_A;
      idx_q        <= IDX_H;
      vec_a_q      <= '0;
      vec_b_q      <= '0;
      pair_count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (xfer && (state_q == COLLECT_A)) vec_a_q <= upd_vec;
      if (xfer && (state_q == COLLECT_B)) vec_b_q <= upd_vec;
      if (write) pair_count_q <= pair_count_q + COUNT_WIDTH'(1);
    end
  end

  assign in1_wr_en   = write;
  assign in2_wr_en   = write;
  assign in1_data_in = vec_a_q;
  assign in2_data_in = vec_b_q;
  assign busy        = (state_q != COLLECT_A) || (idx_q != IDX_H);
  assign pair_count  = pair_count_q;

endmodule

// File: tb/tb_hsi_vector_packer.sv
module tb_hsi_vector_packer;

  localparam int unsigned CW  = 16;
  localparam int unsigned NW  = 8;   // narrow counter so the wrap test stays short
  localparam int unsigned VW  = 3 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [CW-1:0] s_data = '0;
  logic          flush = 1'b0;
  logic          in1_wr_en, in2_wr_en;
  logic [VW-1:0] in1_data_in, in2_data_in;
  logic          in1_full = 1'b0, in2_full = 1'b0;
  logic          busy;
  logic [NW-1:0] pair_count;

  hsi_vector_packer #(.COMPONENT_WIDTH(CW), .COUNT_WIDTH(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush),
    .in1_wr_en(in1_wr_en), .in1_data_in(in1_data_in), .in1_full(in1_full),
    .in2_wr_en(in2_wr_en), .in2_data_in(in2_data_in), .in2_full(in2_full),
    .busy(busy), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced at each falling edge to predict the next rising edge.
  logic [2*VW-1:0] sb_q[$];
  logic [VW-1:0]   m_a, m_b;
  int unsigned     m_idx = 0;
  bit              m_pend = 1'b0;
  logic [NW-1:0]   m_cnt = '0;
  logic [VW-1:0]   last_a = '0, last_b = '0;

  always @(negedge clk) begin
    logic exp_ready, exp_wr;
    logic [2*VW-1:0] front;
    if (!rst_n) begin
      m_idx = 0; m_pend = 1'b0; m_cnt = '0; m_a = '0; m_b = '0;
      sb_q.delete();
    end else begin
      exp_ready = !m_pend && !flush;
      exp_wr    = m_pend && !in1_full && !in2_full && !flush;
      chk("s_ready", VW'(s_ready), VW'(exp_ready));
      chk("in1_wr_en", VW'(in1_wr_en), VW'(exp_wr));
      chk("in2_wr_en", VW'(in2_wr_en), VW'(exp_wr));
      chk("busy", VW'(busy), VW'(m_pend || (m_idx != 0)));
      chk("pair_count", VW'(pair_count), VW'(m_cnt));
      if (m_pend) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", VW'(1), VW'(0));
        end else begin
          front = sb_q[0];
          chk("in1_data_in", in1_data_in, front[2*VW-1:VW]);
          chk("in2_data_in", in2_data_in, front[VW-1:0]);
        end
      end
      if (flush) begin
        if (m_pend && sb_q.size() != 0) void'(sb_q.pop_front());
        m_pend = 1'b0; m_idx = 0;
      end else if (exp_wr) begin
        if (sb_q.size() != 0) front = sb_q.pop_front();
        last_a = in1_data_in; last_b = in2_data_in;
        m_pend = 1'b0; m_cnt = m_cnt + NW'(1);
      end else if (s_valid && exp_ready) begin
        case (m_idx)
          0: m_a[3*CW-1 -: CW] = s_data;
          1: m_a[2*CW-1 -: CW] = s_data;
          2: m_a[CW-1   -: CW] = s_data;
          3: m_b[3*CW-1 -: CW] = s_data;
          4: m_b[2*CW-1 -: CW] = s_data;
          default: m_b[CW-1 -: CW] = s_data;
        endcase
        if (m_idx == 5) begin
          sb_q.push_back({m_a, m_b});
          m_pend = 1'b1; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic send(input logic [CW-1:0] d);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", VW'(0), VW'(1));
  endtask

  task automatic send_pair(input logic [CW-1:0] c0, c1, c2, c3, c4, c5);
    send(c0); send(c1); send(c2); send(c3); send(c4); send(c5);
    s_valid = 1'b0;
  endtask

  task automatic wait_written();
    for (int i = 0; i < 40 && m_pend; i++) begin
      @(posedge clk);
      #1;
    end
    if (m_pend) chk("write_timeout", VW'(0), VW'(1));
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
  endtask

  initial begin
    logic [NW-1:0] cnt_before;
    #1;
    chk("rst_s_ready", VW'(s_ready), VW'(1));
    chk("rst_in1", in1_data_in, '0);
    chk("rst_in2", in2_data_in, '0);
    chk("rst_count", VW'(pair_count), '0);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // back-to-back stream, write one cycle after final transfer
    send_pair(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    wait_written();
    chk("t1_in1", last_a, 48'h000100020003);
    chk("t1_in2", last_b, 48'h000400050006);
    chk("t1_count", VW'(pair_count), VW'(1));

    // negative components stored as raw bits
    send_pair(16'hFFFF, 16'd0, 16'd2, 16'd3, 16'hFFFC, 16'd5);
    wait_written();
    chk("t2_in1", last_a, 48'hFFFF00000002);
    chk("t2_in2", last_b, 48'h0003FFFC0005);

    // FIFO 2 full holds the pair in PUSH
    in2_full = 1'b1;
    send_pair(16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 16'h66);
    cycles(5);
    chk("t3_held", VW'(m_pend), VW'(1));
    in2_full = 1'b0;
    wait_written();
    chk("t3_count", VW'(pair_count), VW'(3));

    // flush after four transfers drops the partial pair
    send(16'hA1); send(16'hA2); send(16'hA3); send(16'hA4);
    s_valid = 1'b0;
    pulse_flush();
    cycles(2);
    chk("t4_busy", VW'(busy), VW'(0));
    send_pair(16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12);
    wait_written();
    chk("t4_in1", last_a, 48'h000700080009);
    chk("t4_in2", last_b, 48'h000A000B000C);

    // flush in PUSH with FIFOs free discards the pair
    in1_full = 1'b1;
    send_pair(16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1);
    cycles(2);
    cnt_before = pair_count;
    in1_full = 1'b0;
    pulse_flush();
    cycles(3);
    chk("t5_count", VW'(pair_count), VW'(cnt_before));
    chk("t5_busy", VW'(busy), VW'(0));

    // counter wrap
    while (m_cnt != '1) begin
      send_pair(CW'($urandom), CW'($urandom), CW'($urandom),
                CW'($urandom), CW'($urandom), CW'($urandom));
      wait_written();
    end
    send_pair(16'hDEAD, 16'hBEEF, 16'h0001, 16'h8000, 16'h7FFF, 16'h1234);
    wait_written();
    chk("t6_wrap", VW'(pair_count), '0);

    // asynchronous reset mid-vector
    send_pair(16'h5, 16'h6, 16'h7, 16'h8, 16'h9, 16'hA);
    wait_written();
    send(16'hC0); send(16'hC1);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in1", in1_data_in, '0);
    chk("arst_in2", in2_data_in, '0);
    chk("arst_wr1", VW'(in1_wr_en), '0);
    chk("arst_wr2", VW'(in2_wr_en), '0);
    chk("arst_count", VW'(pair_count), '0);
    chk("arst_busy", VW'(busy), '0);
    chk("arst_ready", VW'(s_ready), VW'(1));
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    send_pair(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    wait_written();
    chk("post_rst_in1", last_a, 48'h000100020003);
    chk("post_rst_count", VW'(pair_count), VW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
